matriz_max7219_tx: RTL and testbench
====================================

# matriz_max7219_tx

Serializer that drives the eight row vectors of the 8x8 LED matrix out to a MAX7219 display driver over its 3-wire serial interface (DIN/CLK/LOAD). It sits downstream of the matrix row-mapping logic and consumes its eight row outputs. After reset it sends the MAX7219 init sequence, then refreshes all eight digit registers continuously. Each full pass uses a coherent snapshot of the rows, so a pass never mixes rows from different frames.

## Interface

- DATAWIDTH, 8: row width. Must be 8, matching MAX7219 digit width.
- CLK_DIV, 4: system cycles per serial half-period ("tick"), ≥2. The default gives a 6.25 MHz serial clock at 50 MHz.
- INTENSITY, 4'h8: value written to the intensity register (0x0A).

- MatrizTx_CLOCK_50  in  1  system clock. One clock for the whole block.
- MatrizTx_RESET_InHigh  in  1  reset, synchronous, active-high.
- MatrizTx_Fila1_In … MatrizTx_Fila8_In  in  DATAWIDTH each  row data. FilaN goes to digit register N (address 0x0N). Bit 7 is the MSB column.
- MatrizTx_DIN_Out  out  1  serial data to MAX7219 DIN, MSB first.
- MatrizTx_SCLK_Out  out  1  serial clock. MAX7219 samples DIN on the rising edge.
- MatrizTx_LOAD_Out  out  1  frame strobe. Low during a frame; the rising edge latches the 16-bit word.
- MatrizTx_Ready_Out  out  1  high once init is complete; stays high until reset.
- MatrizTx_PassDone_Out  out  1  one-cycle pulse at the end of each 8-row refresh pass.

## Operation

- **Frame word:** 16 bits = {4'h0, addr[3:0], data[7:0]}, sent bit 15 first.
- **Tick generator:** counter runs 0..CLK_DIV-1; a tick fires when it equals CLK_DIV-1. The counter clears on reset, so the first tick after reset falls on cycle CLK_DIV.
- **State machine:** INIT_FRAME → INIT_GAP → (loop 5×) → SNAP → ROW_FRAME → ROW_GAP → (loop 8×) → SNAP …
- **INIT words, in order:**
  - 0x0C01: shutdown off
  - 0x0900: no decode
  - 0x0B07: scan all 8
  - {8'h0A, 4'h0, INTENSITY}
  - 0x0F00: display test off
- **SNAP:** a single system cycle that registers all eight Fila inputs into an internal shadow bank. It then enters ROW_FRAME with digit index 1. Row frames send {4'h0, idx, shadow[idx]} for idx = 1..8.
- **Frame, half-period counter h = 0..32:**
  - First tick of the frame (h=0): LOAD←0, SCLK←0, DIN←bit15.
  - Each following tick, h increments.
  - Odd h: SCLK←1, DIN held.
  - Even h in 2..30: SCLK←0, DIN←next bit.
  - h=32: SCLK←0, LOAD←1, and the frame ends.
  - Result: 16 SCLK rising edges, each with DIN stable for CLK_DIV cycles before it.
- **GAP:** LOAD held high, SCLK low, DIN←0 for 1 further tick. The next frame begins on the tick after that.
- **Ready:** set on the same cycle LOAD rises at the end of the 5th init frame.
- **PassDone:** pulses on the cycle LOAD rises at the end of digit 8.
- **Fila inputs:** ignored except in the SNAP cycle.
- **Reset mid-operation:** takes effect on the next edge. Frame is aborted, LOAD←1, SCLK←0, all counters clear, and init reruns from 0x0C01. A partially clocked word latched by the abort is harmless, because init rewrites every control register.

## Timing

- **Reset values:** DIN=0, SCLK=0, LOAD=1, Ready=0, PassDone=0, shadow bank = 0, tick counter = 0.
- **First LOAD fall:** cycle CLK_DIV after reset deasserts.
- **SCLK period:** 2·CLK_DIV cycles, 50 % duty.
- **Frame + gap:** 34 ticks = 34·CLK_DIV cycles between successive LOAD falls within init.
- **Row-pass boundary:** SNAP adds exactly 1 system cycle before digit 1. The tick counter is held in SNAP, so the tick phase shifts by one cycle.
- **Pass length:** 8·34·CLK_DIV + 1 cycles. With default CLK_DIV this is 1089 cycles ≈ 21.8 µs.
- **LOAD-high time:** ≥ 2·CLK_DIV cycles between frames. This meets MAX7219 tCSW at CLK_DIV ≥ 2.
- **Output timing:** all outputs are registered, with no combinational path from inputs.

## Test plan

- **Reset values:** hold reset 5 cycles with CLK_DIV=2 → LOAD=1, SCLK=0, DIN=0, Ready=0, PassDone=0 throughout. First LOAD fall occurs 2 cycles after release.
- **Init sequence:** monitor samples DIN on SCLK rise, assembling words on LOAD rise → exactly 0x0C01, 0x0900, 0x0B07, 0x0A08, 0x0F00. Ready rises with the 5th LOAD rise. Each frame shows exactly 16 SCLK rises.
- **Row mapping:** Fila1..8 = 0x81, 0x42, 0x24, 0x18, 0x00, 0xFF, 0xA5, 0x3C → frames 0x0181, 0x0242, 0x0324, 0x0418, 0x0500, 0x06FF, 0x07A5, 0x083C in order. PassDone pulses once, on the cycle of the 0x083C LOAD rise. The pass then repeats.
- **Snapshot coherence:** change all Fila to 0x55 during the digit-3 frame → digits 3..8 of the current pass carry the old values. The next pass sends 0x0155 … 0x0855.
- **Timing:** CLK_DIV=4 → SCLK high/low 4 cycles each. LOAD falls are 136 cycles apart within a pass and 137 cycles apart across the SNAP boundary.
- **Reset mid-frame:** assert reset at h=17 of digit 5 → next cycle LOAD=1, SCLK=0, Ready=0. After release, the next captured word is 0x0C01.

Source files
------------

// File: rtl/matriz_max7219_tx.sv
// Streams the MAX7219 init words, then refreshes the eight digit registers from a
// per-pass snapshot of the row inputs over the DIN/CLK/LOAD serial interface.
module matriz_max7219_tx #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input  logic                 MatrizTx_CLOCK_50,
  input  logic                 MatrizTx_RESET_InHigh,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila1_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila2_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila3_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila4_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila5_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila6_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila7_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila8_In,
  output logic                 MatrizTx_DIN_Out,
  output logic                 MatrizTx_SCLK_Out,
  output logic                 MatrizTx_LOAD_Out,
  output logic                 MatrizTx_Ready_Out,
  output logic                 MatrizTx_PassDone_Out
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {StInitFrame, StInitGap, StSnap, StRowFrame, StRowGap} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [5:0]            h_q, h_d, h_inc;
  logic                  started_q, started_d;
  logic [3:0]            idx_q, idx_d;
  logic [15:0]           sh_q, sh_d, word;
  logic                  din_q, din_d, sclk_q, sclk_d, load_q, load_d;
  logic                  ready_q, ready_d, pass_done_q, pass_done_d;
  logic [DATAWIDTH-1:0]  shadow_q [8];
  logic [DATAWIDTH-1:0]  shadow_d [8];
  logic [DATAWIDTH-1:0]  fila [8];
  logic                  tick, in_frame, in_gap, frame_end;
  logic [2:0]            row_sel;

  assign fila[0] = MatrizTx_Fila1_In;
  assign fila[1] = MatrizTx_Fila2_In;
  assign fila[2] = MatrizTx_Fila3_In;
  assign fila[3] = MatrizTx_Fila4_In;
  assign fila[4] = MatrizTx_Fila5_In;
  assign fila[5] = MatrizTx_Fila6_In;
  assign fila[6] = MatrizTx_Fila7_In;
  assign fila[7] = MatrizTx_Fila8_In;

  assign tick      = (tick_cnt_q == CntW'(CLK_DIV - 1));
  assign in_frame  = (state_q == StInitFrame) || (state_q == StRowFrame);
  assign in_gap    = (state_q == StInitGap) || (state_q == StRowGap);
  assign h_inc     = h_q + 6'd1;
  assign frame_end = in_frame && tick && started_q && (h_inc == 6'd32);
  assign row_sel   = 3'(idx_q - 4'd1);

  always_comb begin
    word = 16'h0F00;
    if (state_q == StRowFrame) begin
      word = {4'h0, idx_q, shadow_q[row_sel]};
    end else begin
      case (idx_q)
        4'd0:    word = 16'h0C01;
        4'd1:    word = 16'h0900;
        4'd2:    word = 16'h0B07;
        4'd3:    word = {8'h0A, 4'h0, INTENSITY};
        default: word = 16'h0F00;
      endcase
    end
  end

  always_ff @(posedge MatrizTx_CLOCK_50) begin
    if (MatrizTx_RESET_InHigh) begin
      state_q     <= StInitFrame;
      tick_cnt_q  <= '0;
      h_q         <= '0;
      started_q   <= 1'b0;
      idx_q       <= '0;
      sh_q        <= '0;
      din_q       <= 1'b0;
      sclk_q      <= 1'b0;
      load_q      <= 1'b1;
      ready_q     <= 1'b0;
      pass_done_q <= 1'b0;
      for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      h_q         <= h_d;
      started_q   <= started_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      din_q       <= din_d;
      sclk_q      <= sclk_d;
      load_q      <= load_d;
      ready_q     <= ready_d;
      pass_done_q <= pass_done_d;
      for (int i = 0; i < 8; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInitFrame: if (frame_end) state_d = StInitGap;
      StInitGap:   if (tick) state_d = (idx_q == 4'd4) ? StSnap : StInitFrame;
      StSnap:      state_d = StRowFrame;
      StRowFrame:  if (frame_end) state_d = StRowGap;
      StRowGap:    if (tick) state_d = (idx_q == 4'd8) ? StSnap : StRowFrame;
      default:     state_d = StInitFrame;
    endcase
  end

  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + CntW'(1);
    h_d         = h_q;
    started_d   = started_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    din_d       = din_q;
    sclk_d      = sclk_q;
    load_d      = load_q;
    ready_d     = ready_q;
    pass_done_d = 1'b0;
    for (int i = 0; i < 8; i++) shadow_d[i] = shadow_q[i];

    if (state_q == StSnap) begin
      // Tick phase freezes here so the snapshot costs exactly one system cycle.
      tick_cnt_d = tick_cnt_q;
      idx_d      = 4'd1;
      for (int i = 0; i < 8; i++) shadow_d[i] = fila[i];
    end else if (in_frame && tick) begin
      if (!started_q) begin
        started_d = 1'b1;
        h_d       = '0;
        load_d    = 1'b0;
        sclk_d    = 1'b0;
        din_d     = word[15];
        sh_d      = {word[14:0], 1'b0};
      end else begin
        h_d = h_inc;
        if (h_inc[0]) begin
          sclk_d = 1'b1;
        end else if (frame_end) begin
          sclk_d    = 1'b0;
          load_d    = 1'b1;
          started_d = 1'b0;
          if (state_q == StInitFrame && idx_q == 4'd4) ready_d = 1'b1;
          if (state_q == StRowFrame && idx_q == 4'd8) pass_done_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          din_d  = sh_q[15];
          sh_d   = {sh_q[14:0], 1'b0};
        end
      end
    end else if (in_gap && tick) begin
      load_d = 1'b1;
      sclk_d = 1'b0;
      din_d  = 1'b0;
      idx_d  = idx_q + 4'd1;
    end
  end

  assign MatrizTx_DIN_Out      = din_q;
  assign MatrizTx_SCLK_Out     = sclk_q;
  assign MatrizTx_LOAD_Out     = load_q;
  assign MatrizTx_Ready_Out    = ready_q;
  assign MatrizTx_PassDone_Out = pass_done_q;

endmodule

// File: tb/tb_matriz_max7219_tx.sv
// Decodes the serial stream back into 16-bit words and checks them against the
// expected init table and per-pass row snapshots, plus serial timing.
module tb_matriz_max7219_tx;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FRAME_CYC = 34 * CLK_DIV;

  typedef struct packed {
    logic [15:0] word;
    logic [31:0] nbits;
    logic [31:0] fall;
    logic        ready;
    logic        pd;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fila [8];
  logic       din, sclk, load, ready, pd;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Monitor state
  rec_t        mem [512];
  int unsigned wr_cnt = 0;
  int unsigned rd_cnt = 0;
  int unsigned cyc = 0;
  int unsigned bad_high = 0, bad_period = 0, pd_stray = 0;

  always #5 clk = ~clk;

  matriz_max7219_tx #(
    .DATAWIDTH(8),
    .CLK_DIV  (CLK_DIV),
    .INTENSITY(4'h8)
  ) dut (
    .MatrizTx_CLOCK_50    (clk),
    .MatrizTx_RESET_InHigh(rst),
    .MatrizTx_Fila1_In    (fila[0]),
    .MatrizTx_Fila2_In    (fila[1]),
    .MatrizTx_Fila3_In    (fila[2]),
    .MatrizTx_Fila4_In    (fila[3]),
    .MatrizTx_Fila5_In    (fila[4]),
    .MatrizTx_Fila6_In    (fila[5]),
    .MatrizTx_Fila7_In    (fila[6]),
    .MatrizTx_Fila8_In    (fila[7]),
    .MatrizTx_DIN_Out     (din),
    .MatrizTx_SCLK_Out    (sclk),
    .MatrizTx_LOAD_Out    (load),
    .MatrizTx_Ready_Out   (ready),
    .MatrizTx_PassDone_Out(pd)
  );

  // Serial decoder: behaves like the MAX7219 shift register
  logic        m_psclk = 1'b0, m_pload = 1'b1;
  logic [15:0] m_word = '0;
  int unsigned m_nbits = 0, m_fall = 0, m_last_rise = 0, m_high_start = 0;
  bit          m_have_rise = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      wr_cnt = 0;
      m_psclk = 1'b0;
      m_pload = 1'b1;
      m_nbits = 0;
      m_have_rise = 0;
    end else begin
      if (m_pload && !load) begin
        m_fall = cyc;
        m_word = '0;
        m_nbits = 0;
        m_have_rise = 0;
      end
      if (!m_psclk && sclk) begin
        m_word = {m_word[14:0], din};
        m_nbits++;
        if (m_have_rise && (cyc - m_last_rise) != 2 * CLK_DIV) bad_period++;
        m_have_rise = 1;
        m_last_rise = cyc;
        m_high_start = cyc;
      end
      if (m_psclk && !sclk && (cyc - m_high_start) != CLK_DIV) bad_high++;
      if (!m_pload && load) begin
        mem[wr_cnt % 512] = '{word: m_word, nbits: m_nbits, fall: m_fall, ready: ready, pd: pd};
        wr_cnt++;
      end else if (pd) begin
        pd_stray++;
      end
      m_psclk = sclk;
      m_pload = load;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic get_word(input string tag, output rec_t r);
    int unsigned n = 0;
    while (wr_cnt == rd_cnt && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(wr_cnt != rd_cnt), 32'd1);
    if (wr_cnt != rd_cnt) begin
      r = mem[rd_cnt % 512];
      rd_cnt++;
    end else begin
      r = '0;
    end
  endtask

  task automatic first_fall(input string tag);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (load && n < 10 * CLK_DIV);
    chk(tag, n, CLK_DIV);
  endtask

  task automatic wait_load_low();
    int unsigned n = 0;
    while (load && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    logic [15:0] t [5];
    t = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A08, 16'h0F00};
    return t[i];
  endfunction

  initial begin
    logic [7:0]  cur [8];
    logic [7:0]  nxt [8];
    rec_t        r;
    int unsigned prev_fall;
    int unsigned change_at;
    int unsigned rises, n;
    logic        ps;

    cur = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h00, 8'hFF, 8'hA5, 8'h3C};
    fila = cur;
    rst = 1'b1;

    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", {27'b0, load, sclk, din, ready, pd}, 32'h10);
    end
    rst = 1'b0;
    rd_cnt = 0;
    first_fall("first_load_fall");

    // Init sequence
    prev_fall = 0;
    for (int i = 0; i < 5; i++) begin
      get_word($sformatf("init%0d", i), r);
      chk($sformatf("init%0d_word", i), 32'(r.word), 32'(init_word(i)));
      chk($sformatf("init%0d_bits", i), r.nbits, 32'd16);
      chk($sformatf("init%0d_ready", i), 32'(r.ready), 32'(i == 4));
      chk($sformatf("init%0d_pd", i), 32'(r.pd), 32'd0);
      if (i > 0) chk($sformatf("init%0d_fall_gap", i), r.fall - prev_fall, FRAME_CYC);
      prev_fall = r.fall;
    end
    chk("ready_stays", 32'(ready), 32'd1);

    // Row passes: the rows change mid-pass; the pass must still use its snapshot
    for (int p = 0; p < 4; p++) begin
      change_at = (p == 0) ? 3 : $urandom_range(2, 7);
      for (int k = 0; k < 8; k++) nxt[k] = (p == 0) ? 8'h55 : 8'($urandom_range(0, 255));
      for (int d = 1; d <= 8; d++) begin
        get_word($sformatf("p%0d_d%0d", p, d), r);
        chk($sformatf("p%0d_d%0d_word", p, d), 32'(r.word), 32'({4'h0, 4'(d), cur[d-1]}));
        chk($sformatf("p%0d_d%0d_bits", p, d), r.nbits, 32'd16);
        chk($sformatf("p%0d_d%0d_pd", p, d), 32'(r.pd), 32'(d == 8));
        chk($sformatf("p%0d_d%0d_fall_gap", p, d), r.fall - prev_fall,
            FRAME_CYC + ((d == 1) ? 1 : 0));
        prev_fall = r.fall;
        if (d == change_at - 1) begin
          wait_load_low();
          fila = nxt;
        end
      end
      cur = nxt;
    end

    // Reset at h=17 of digit 5
    for (int d = 1; d <= 4; d++) begin
      get_word($sformatf("p4_d%0d", d), r);
      chk($sformatf("p4_d%0d_word", d), 32'(r.word), 32'({4'h0, 4'(d), cur[d-1]}));
    end
    wait_load_low();
    ps = sclk;
    rises = 0;
    n = 0;
    while (rises < 9 && n < 1000) begin
      @(negedge clk);
      if (!ps && sclk) rises++;
      ps = sclk;
      n++;
    end
    chk("midrst_rises", rises, 32'd9);
    rst = 1'b1;
    rd_cnt = 0;
    @(negedge clk);
    chk("midrst_outputs", {29'b0, load, sclk, ready}, 32'h4);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    first_fall("midrst_first_fall");
    get_word("after_rst", r);
    chk("after_rst_word", 32'(r.word), 32'h0C01);
    chk("after_rst_bits", r.nbits, 32'd16);
    chk("after_rst_ready", 32'(r.ready), 32'd0);

    chk("sclk_high_len", bad_high, 32'd0);
    chk("sclk_period", bad_period, 32'd0);
    chk("passdone_stray", pd_stray, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
